// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, phase and sequencer-state definitions for the CPU controller slice.
package cpu_pkg;
   localparam int DEF_OP_W   = 3;
   localparam int DEF_ADDR_W = 5;
   typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_t;
   localparam logic [2:0] PH_INST_ADDR  = 3'd0;
   localparam logic [2:0] PH_INST_FETCH = 3'd1;
   localparam logic [2:0] PH_INST_LOAD  = 3'd2;
   localparam logic [2:0] PH_IDLE       = 3'd3;
   localparam logic [2:0] PH_OP_ADDR    = 3'd4;
   localparam logic [2:0] PH_OP_FETCH   = 3'd5;
   localparam logic [2:0] PH_ALU_OP     = 3'd6;
   localparam logic [2:0] PH_STORE      = 3'd7;
   typedef enum logic {RUN, HALTED} seq_state_t;
endpackage

// File: rtl/cpu_ir_reg.sv
// cpu_ir_reg: instruction register and accumulator-zero flag with their load qualification.
module cpu_ir_reg import cpu_pkg::*; #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic [2:0]        phase_i,
   input  logic              ld_ir_i,
   input  logic              ld_ac_i,
   input  logic              alu_zero_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] ir_o,
   output logic              zero_o
);
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              zero_q, zero_d;
   // en_i is only high while running and not halted, so halted cycles ignore both loads
   always_comb begin
      ir_d   = (en_i && ld_ir_i && (phase_i == PH_INST_LOAD || phase_i == PH_IDLE)) ? data_i : ir_q;
      zero_d = (en_i && ld_ac_i) ? alu_zero_i : zero_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q   <= '0;
         zero_q <= 1'b0;
      end else begin
         ir_q   <= ir_d;
         zero_q <= zero_d;
      end
   end
   assign ir_o   = ir_q;
   assign zero_o = zero_q;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: 8-phase instruction sequencer with halt/resume FSM, IR, zero flag
// and retired-instruction counter.
module cpu_sequencer import cpu_pkg::*; #(
   parameter int DATA_W = 8,
   parameter int OP_W   = DEF_OP_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              resume,
   input  logic [DATA_W-1:0] data_in,
   input  logic              ld_ir,
   input  logic              ld_ac,
   input  logic              alu_zero,
   input  logic              halt,
   output logic [2:0]        phase,
   output logic [OP_W-1:0]   opcode,
   output logic [ADDR_W-1:0] ir_addr,
   output logic              zero,
   output logic              halted,
   output logic [CNT_W-1:0]  instr_count
);
   seq_state_t        state_q, state_d;
   logic [2:0]        phase_q, phase_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] ir;
   logic              active, retire;
   assign active = run && state_q == RUN;
   assign retire = active && phase_q == PH_STORE;
   // halt entry lands on phase 5 naturally; resume jumps straight to phase 6
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      if (active) begin
         phase_d = phase_q + 3'd1;
         state_d = (halt && phase_q == PH_OP_ADDR) ? HALTED : RUN;
      end else if (run && resume) begin
         phase_d = PH_ALU_OP;
         state_d = RUN;
      end
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         phase_q <= PH_INST_ADDR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
      end
   end
   cpu_ir_reg #(.DATA_W(DATA_W)) u_ir (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (active),
      .phase_i    (phase_q),
      .ld_ir_i    (ld_ir),
      .ld_ac_i    (ld_ac),
      .alu_zero_i (alu_zero),
      .data_i     (data_in),
      .ir_o       (ir),
      .zero_o     (zero)
   );
   assign phase       = phase_q;
   assign opcode      = ir[DATA_W-1 -: OP_W];
   assign ir_addr     = ir[ADDR_W-1:0];
   assign halted      = state_q == HALTED;
   assign instr_count = cnt_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed self-checking bench for cpu_sequencer, including a CNT_W=2 instance.
module tb_cpu_sequencer;
   logic clk = 1'b0, rst_n = 1'b1, run = 1'b1, resume = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic ld_ir = 1'b0, ld_ac = 1'b0, alu_zero = 1'b0, halt = 1'b0;
   logic [2:0] phase, phase2, opcode, opcode2;
   logic [4:0] ir_addr, ir_addr2;
   logic zero, zero2, halted, halted2;
   logic [15:0] instr_count;
   logic [1:0] instr_count2;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   cpu_sequencer dut (
      .clk(clk), .rst_n(rst_n), .run(run), .resume(resume), .data_in(data_in),
      .ld_ir(ld_ir), .ld_ac(ld_ac), .alu_zero(alu_zero), .halt(halt),
      .phase(phase), .opcode(opcode), .ir_addr(ir_addr), .zero(zero),
      .halted(halted), .instr_count(instr_count)
   );

   cpu_sequencer #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .run(run), .resume(resume), .data_in(data_in),
      .ld_ir(ld_ir), .ld_ac(ld_ac), .alu_zero(alu_zero), .halt(halt),
      .phase(phase2), .opcode(opcode2), .ir_addr(ir_addr2), .zero(zero2),
      .halted(halted2), .instr_count(instr_count2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " phase"}, 32'(phase), 0);
      chk({tag, " opcode"}, 32'(opcode), 0);
      chk({tag, " ir_addr"}, 32'(ir_addr), 0);
      chk({tag, " zero"}, 32'(zero), 0);
      chk({tag, " halted"}, 32'(halted), 0);
      chk({tag, " count"}, 32'(instr_count), 0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      // 1: two full instructions, IR loaded with A7 in phases 2-3
      for (int k = 0; k < 16; k++) begin
         ld_ir = (k % 8 == 2) || (k % 8 == 3);
         data_in = 8'hA7;
         tick();
         chk("t1 phase", 32'(phase), (k + 1) % 8);
         chk("t1 opcode", 32'(opcode), (k >= 2) ? 5 : 0);
         chk("t1 ir_addr", 32'(ir_addr), (k >= 2) ? 7 : 0);
         chk("t1 count", 32'(instr_count), (k >= 15) ? 2 : (k >= 7) ? 1 : 0);
      end
      ld_ir = 1'b0;
      // 2: HLT fetched, halt at phase 4, held 10 edges, resume
      data_in = 8'h00;
      tick(); tick();
      ld_ir = 1'b1;
      tick(); tick();
      ld_ir = 1'b0;
      chk("t2 phase4", 32'(phase), 4);
      chk("t2 opcode hlt", 32'(opcode), 0);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("t2 halt phase", 32'(phase), 5);
      chk("t2 halted", 32'(halted), 1);
      ld_ir = 1'b1; data_in = 8'hFF; ld_ac = 1'b1; alu_zero = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t2 hold phase", 32'(phase), 5);
         chk("t2 hold halted", 32'(halted), 1);
      end
      chk("t2 hold opcode", 32'(opcode), 0);
      chk("t2 hold zero", 32'(zero), 0);
      ld_ir = 1'b0; ld_ac = 1'b0; alu_zero = 1'b0; data_in = 8'h00;
      resume = 1'b1;
      tick();
      resume = 1'b0;
      chk("t2 resume phase", 32'(phase), 6);
      chk("t2 resume halted", 32'(halted), 0);
      tick();
      chk("t2 phase7", 32'(phase), 7);
      chk("t2 count pre", 32'(instr_count), 2);
      tick();
      chk("t2 phase0", 32'(phase), 0);
      chk("t2 count", 32'(instr_count), 3);
      // 3: zero flag loads only with ld_ac
      repeat (7) tick();
      ld_ac = 1'b1; alu_zero = 1'b1;
      tick();
      chk("t3 zero set", 32'(zero), 1);
      ld_ac = 1'b0; alu_zero = 1'b0;
      repeat (7) tick();
      tick();
      chk("t3 zero hold", 32'(zero), 1);
      repeat (7) tick();
      ld_ac = 1'b1; alu_zero = 1'b0;
      tick();
      ld_ac = 1'b0;
      chk("t3 zero clr", 32'(zero), 0);
      chk("t3 count", 32'(instr_count), 6);
      // 4: run=0 freezes everything; ld_ir outside phases 2-3 ignored
      tick(); tick();
      ld_ir = 1'b1; data_in = 8'h3C;
      tick();
      chk("t4 opcode", 32'(opcode), 1);
      chk("t4 ir_addr", 32'(ir_addr), 5'h1C);
      run = 1'b0;
      for (int k = 0; k < 5; k++) begin
         data_in = ~data_in;
         tick();
         chk("t4 frozen phase", 32'(phase), 3);
         chk("t4 frozen ir", {24'h0, opcode, ir_addr}, 8'h3C);
      end
      ld_ir = 1'b0; run = 1'b1;
      tick();
      chk("t4 run phase", 32'(phase), 4);
      tick();
      ld_ir = 1'b1; data_in = 8'hFF;
      tick();
      ld_ir = 1'b0;
      chk("t4 ph5 ir", {24'h0, opcode, ir_addr}, 8'h3C);
      chk("t4 phase6", 32'(phase), 6);
      chk("t4 count", 32'(instr_count), 6);
      // 5: asynchronous reset mid-cycle in RUN and in HALTED
      #2 rst_n = 1'b0;
      #1 chk_all_zero("t5 run rst");
      rst_n = 1'b1;
      tick();
      chk("t5 restart", 32'(phase), 1);
      tick(); tick(); tick();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("t5 halted", 32'(halted), 1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("t5 halt rst");
      rst_n = 1'b1;
      tick();
      chk("t5 restart2", 32'(phase), 1);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("t5 halt ph1 phase", 32'(phase), 2);
      chk("t5 halt ph1 halted", 32'(halted), 0);
      // 6: resume in RUN ignored; 2-bit counter wraps
      resume = 1'b1;
      tick();
      chk("t6 resume run phase", 32'(phase), 3);
      chk("t6 resume run halted", 32'(halted), 0);
      repeat (5) tick();
      chk("t6 phase0", 32'(phase), 0);
      chk("t6 cnt2 1", 32'(instr_count2), 1);
      for (int i = 2; i <= 5; i++) begin
         repeat (8) tick();
         chk("t6 phase", 32'(phase), 0);
         chk("t6 cnt16", 32'(instr_count), i);
         chk("t6 cnt2", 32'(instr_count2), i % 4);
      end
      resume = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Upstream stage of the instruction controller. Generates the 3-bit `phase` that steps the controller through its 8-phase instruction cycle.
- Holds the instruction register (IR), which supplies `opcode` to the controller.
- Holds the registered `zero` flag, which supplies `zero` to the controller.
- Consumes the controller's `ld_ir`, `ld_ac` and `halt` outputs, and implements the halt/resume state machine.

Parameters:
- DATA_W, 8: memory data bus width; must equal OP_W+ADDR_W.
- OP_W, 3: opcode field width, IR[DATA_W-1 -: OP_W].
- ADDR_W, 5: operand address field width, IR[ADDR_W-1:0].
- CNT_W, 16: retired-instruction counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  global enable; when 0 all state holds.
- resume  in  1  leave HALTED; sampled only in HALTED.
- data_in  in  DATA_W  memory read data.
- ld_ir  in  1  from controller: load IR.
- ld_ac  in  1  from controller: accumulator load this edge.
- alu_zero  in  1  1 when the value being loaded into the accumulator is zero.
- halt  in  1  from controller: HLT decoded.
- phase  out  3  current instruction phase.
- opcode  out  OP_W  IR opcode field.
- ir_addr  out  ADDR_W  IR address field.
- zero  out  1  registered accumulator-zero flag.
- halted  out  1  1 while in HALTED.
- instr_count  out  CNT_W  instructions retired.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low. All state updates on `clk` rising edge only.
- Reset values (immediate on rst_n=0, from any state or phase):
  - phase=0, IR=0 (so opcode=0, ir_addr=0), zero=0, halted=0, instr_count=0.
  - FSM=RUN.
- FSM states are RUN and HALTED. `halted` is a registered copy of (state==HALTED).
- run=0: phase, IR, zero, FSM and instr_count all hold. `run` overrides every other input.
- RUN, run=1:
  - phase <= phase+1 each edge, wrapping 7->0.
  - instr_count <= instr_count+1 on the 7->0 edge, wrapping modulo 2^CNT_W.
- Halt entry: RUN, run=1, phase==4, halt=1 -> next edge: phase=5, FSM=HALTED.
  - The controller's single phase-4 inc_pc already occurred.
  - halt at any phase other than 4 is ignored.
- HALTED:
  - phase frozen at 5; controller outputs are all 0 for HLT at phase 5.
  - IR and zero hold; ld_ir and ld_ac are ignored.
- Resume: HALTED, run=1, resume=1 -> next edge: phase=6, FSM=RUN, halted=0. Execution continues 6,7,0; the 7->0 edge counts the HLT as retired.
  - resume while in RUN is ignored.
  - resume with run=0 is ignored.
- IR load: RUN, run=1, ld_ir=1, phase in {2,3} -> IR <= data_in.
  - Repeated capture in phases 2 and 3 is legal.
  - ld_ir in any other phase is ignored.
  - opcode and ir_addr are direct slices of IR, so they are valid from the edge after the first load.
- Zero flag: RUN, run=1, ld_ac=1 -> zero <= alu_zero on the same edge the accumulator loads. Otherwise zero holds.
- Latency: every output is registered; the response appears one edge after the qualifying input. There are no combinational paths from inputs to outputs.
- Simultaneous events:
  - halt and ld_ac at phase 4: halt wins, and ld_ac is legal only at phase 7 anyway.
  - Reset asserted during a halt-entry edge: reset wins.

Decomposition:
- Package cpu_pkg:
  - opcode_t enum: HLT=0, SKZ, ADD, AND, XOR, LDA, STO, JMP.
  - Phase localparams PH_INST_ADDR=0 through PH_STORE=7.
  - seq_state_t {RUN, HALTED}.
  - OP_W and ADDR_W defaults.
- Sub-module cpu_ir_reg (IR, zero flag and load qualification). Phase counter and FSM stay in the top module.

Test Plan:
1. Reset, run=1 for 16 edges; ld_ir=1 at phases 2-3 with data_in=8'hA7 -> phase 0..7,0..7; opcode=3'b101 and ir_addr=5'h07 from the edge after phase 2; instr_count=2.
2. data_in=8'h00, halt=1 at phase 4 -> phase=5, halted=1, held for 10 edges; single resume pulse -> phase 6,7,0, halted=0, instr_count +1.
3. Phase 7, ld_ac=1, alu_zero=1 -> zero=1; next instruction ld_ac=0, alu_zero=0 -> zero stays 1; then ld_ac=1, alu_zero=0 -> zero=0.
4. run=0 at phase 3 for 5 edges while data_in toggles and ld_ir=1 -> phase stays 3 and IR unchanged; run=1 -> phase 4. Also ld_ir=1 at phase 5 with data_in=8'hFF -> IR unchanged.
5. rst_n pulsed low mid-cycle at phase 6 in RUN, and again while HALTED -> all outputs 0 immediately, before the next clock edge; counting restarts from phase 0.
6. CNT_W=2, run 5 full instructions -> instr_count 1,2,3,0,1; resume pulsed in RUN -> no effect.
